stage_fetch1: RTL
=================

# stage_fetch1

Second fetch stage: takes a PC and speculation ID from fetch0, issues a single-word request to the instruction cache/memory port and waits for the response. It then holds the instruction word, or the fetch fault, until decode accepts it. It sits between fetch0 and stage_decode. It discards in-flight results on a pipeline redirect (`de_setpc`) or CSR kill.

## Interface
Parameters: none.

Ports:
- `clk_core` in 1: core clock; all state updates on its rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `fe0_valid` in 1: fetch0 presents a fetch.
- `fe0_pc` in 30 [31:2]: word PC of that fetch.
- `fe0_specid` in 1: speculation ID tag.
- `fe0_exc` in 1: fetch0 already faulted; no memory access is made.
- `fe1_stall` out 1: fetch0 must hold its outputs.
- `ic_req_valid` out 1: memory request valid.
- `ic_req_ready` in 1: memory accepts the request this cycle.
- `ic_req_addr` out 30 [31:2]: request word address.
- `ic_resp_valid` in 1: response word present (one cycle per accepted request).
- `ic_resp_data` in 32: instruction word.
- `ic_resp_err` in 1: access fault on this response.
- `fe1_valid` out 1: instruction/fault presented to decode.
- `de_stall` in 1: decode not accepting.
- `fe1_exc` out 1: presented item is an instruction fault.
- `fe1_pc` out 30 [31:2]: PC of the presented item.
- `fe1_specid` out 1: speculation ID of the presented item.
- `fe1_insn` out 32: instruction word; 0 when `fe1_exc`.
- `de_setpc` in 1: redirect from decode; flush.
- `csr_kill` in 1: trap/return kill; flush.

## Operation
- `flush = de_setpc | csr_kill`.
- `accept = fe0_valid & ~fe1_stall & ~flush`. fe0 data is never captured in a flush cycle, because fetch0's output that cycle is wrong-path.
- States:
  - IDLE: nothing held.
  - REQ: request pending.
  - WAIT: request accepted, awaiting response.
  - HOLD: item presented to decode.
  - DRAIN: discarding an orphaned response.
- Transitions:
  - IDLE, on accept:
    - `fe0_exc=1` → HOLD, with `fe1_exc=1` and `insn=0`.
    - otherwise → REQ, latching pc and specid.
  - REQ:
    - `ic_req_valid=1`, `ic_req_addr=pc_r`.
    - `ic_req_ready` → WAIT.
    - flush without ready → IDLE.
    - flush with ready in the same cycle → DRAIN.
  - WAIT:
    - `ic_resp_valid` → HOLD; latch `insn=ic_resp_err?0:data` and `exc=ic_resp_err`.
    - flush without resp → DRAIN.
    - flush with resp → IDLE, response dropped.
  - HOLD:
    - `fe1_valid=1`.
    - flush → IDLE.
    - `~de_stall` → item consumed. Go to the accept result (REQ/HOLD) if accept, else IDLE.
    - `de_stall` → remain; outputs stable.
  - DRAIN:
    - `ic_resp_valid` → IDLE, data discarded.
    - fetch0 is stalled throughout.
- `fe1_stall = (state∈{REQ,WAIT,DRAIN}) | (state==HOLD & de_stall)`.
- `fe1_pc`, `fe1_specid`, `fe1_insn`, `fe1_exc` are registered and change only on entry to HOLD.
- Outside HOLD they keep their last values; `fe1_exc` is qualified by the consumer only when `fe1_valid`.
- An `ic_resp_valid` in IDLE/REQ/HOLD is a protocol error; it is ignored (assertion in bench).

## Timing
- Reset values:
  - state IDLE.
  - `fe1_valid`, `fe1_exc`, `fe1_stall`, `ic_req_valid` = 0.
  - `fe1_pc`, `ic_req_addr` = 0; `fe1_insn` = 0; `fe1_specid` = 0.
- Reset mid-operation abandons any outstanding request. The memory port shares `reset`, so no stale response follows.
- Accept at edge N:
  - `ic_req_valid` high in cycle N+1.
  - With zero-wait memory (ready in N+1, resp in N+2): HOLD and `fe1_valid` in N+3.
- Fault path (`fe0_exc`): `fe1_valid` in N+1, no memory traffic.
- Best-case throughput: one instruction per 3 cycles. Back-to-back accept from HOLD is allowed in the consume cycle.
- Flush takes effect at the same edge: `fe1_valid` is 0 in the next cycle.

## Structure
- `fe1_state_t` enum (IDLE, REQ, WAIT, HOLD, DRAIN) goes in the shared defines package alongside `ecause_t`.
- No sub-module: one FSM and a holding register.

## Test plan
- fe0 pc=0x1000>>2, ready and resp each one cycle later, data 0x00500093, de_stall=0 → `fe1_valid` for exactly one cycle, `fe1_pc`=0x400, `fe1_insn`=0x00500093, `fe1_exc`=0.
- Same fetch with `de_stall` held 4 cycles in HOLD → `fe1_valid` and all outputs stable 5 cycles, `fe1_stall`=1 for 4; new fe0 accepted in the release cycle.
- `ic_resp_err`=1 with data 0xDEADBEEF → `fe1_exc`=1, `fe1_insn`=0, `fe1_valid`=1.
- `de_setpc` during WAIT, resp arrives 3 cycles later with 0x12345678 → DRAIN, `fe1_stall`=1, response discarded, `fe1_valid` never 1, IDLE after resp.
- `de_setpc` in the same cycle as `ic_req_ready` → DRAIN, the following response dropped. `csr_kill` in HOLD → `fe1_valid`=0 the next cycle.
- `fe0_exc`=1 with pc=0x2000>>2 → no `ic_req_valid`, `fe1_valid`/`fe1_exc`=1 the next cycle. Reset asserted in WAIT → all outputs 0 the next cycle.

Source files
------------

// File: rtl/stage_fetch1_pkg.sv
// Shared definitions for the fetch1 stage.
// Contents:
//   fe1_state_t    - fetch1 FSM state encoding (also exported as a debug port)
//   ecause_t       - exception cause codes shared with later stages
//   fe1_stalls_fe0 - whether fetch1 holds fetch0 in a given state
package stage_fetch1_pkg;

  localparam int PC_W   = 30;
  localparam int INSN_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } fe1_state_t;

  typedef enum logic [3:0] {
    EC_INSN_MISALIGN = 4'd0,
    EC_INSN_FAULT    = 4'd1,
    EC_ILLEGAL       = 4'd2,
    EC_BREAKPOINT    = 4'd3,
    EC_ECALL         = 4'd11
  } ecause_t;

  // Fetch0 must hold while a memory transaction is open or pending, and
  // while decode refuses the item currently held.
  function automatic logic fe1_stalls_fe0(fe1_state_t s, logic de_stall);
    return (s == S_REQ) || (s == S_WAIT) || (s == S_DRAIN) ||
           ((s == S_HOLD) && de_stall);
  endfunction

endpackage

// File: rtl/stage_fetch1_if.sv
// Signal bundle around the fetch1 stage: fetch0 input side, instruction
// memory request/response port, decode output side and flush controls.
// Modports:
//   master - the fetch1 stage itself
//   slave  - the surrounding pipeline / memory (used by the testbench)
//
// Handshake semantics:
//   fe0_valid / fe1_stall  : a fetch moves from fetch0 when fe0_valid=1 and
//                            fe1_stall=0 at a rising edge (and no flush).
//   ic_req_valid / ready   : a request transfers when both are 1 at an edge;
//                            exactly one ic_resp_valid cycle follows later.
//   fe1_valid / de_stall   : an item is consumed when fe1_valid=1 and
//                            de_stall=0 at an edge (and no flush).
interface stage_fetch1_if;
  import stage_fetch1_pkg::*;

  logic              fe0_valid;
  logic [PC_W-1:0]   fe0_pc;
  logic              fe0_specid;
  logic              fe0_exc;
  logic              fe1_stall;

  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [PC_W-1:0]   ic_req_addr;
  logic              ic_resp_valid;
  logic [INSN_W-1:0] ic_resp_data;
  logic              ic_resp_err;

  logic              fe1_valid;
  logic              de_stall;
  logic              fe1_exc;
  logic [PC_W-1:0]   fe1_pc;
  logic              fe1_specid;
  logic [INSN_W-1:0] fe1_insn;

  logic              de_setpc;
  logic              csr_kill;

  modport master (
    input  fe0_valid, fe0_pc, fe0_specid, fe0_exc,
    input  ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_err,
    input  de_stall, de_setpc, csr_kill,
    output fe1_stall, ic_req_valid, ic_req_addr,
    output fe1_valid, fe1_exc, fe1_pc, fe1_specid, fe1_insn
  );

  modport slave (
    output fe0_valid, fe0_pc, fe0_specid, fe0_exc,
    output ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_err,
    output de_stall, de_setpc, csr_kill,
    input  fe1_stall, ic_req_valid, ic_req_addr,
    input  fe1_valid, fe1_exc, fe1_pc, fe1_specid, fe1_insn
  );

endinterface

// File: rtl/stage_fetch1.sv
// Second fetch stage. Takes a PC/specid from fetch0, issues one word request
// to instruction memory, waits for the response and holds the instruction
// (or the fault) until decode consumes it. A flush (de_setpc | csr_kill)
// discards whatever is in flight; a response still owed by memory after a
// flush is swallowed in DRAIN.
// Ports:
//   clk_core - core clock, all state changes on its rising edge
//   reset    - synchronous active-high reset
//   bus      - stage_fetch1_if.master (fetch0, memory, decode, flush signals)
//   state    - current FSM state, debug visibility
module stage_fetch1
  import stage_fetch1_pkg::*;
(
  input  logic                  clk_core,
  input  logic                  reset,
  stage_fetch1_if.master        bus,
  output fe1_state_t            state
);

  fe1_state_t        state_q, state_d;
  logic              flush, accept;
  logic              load_req, load_fault, load_resp;

  logic              fe1_valid, ic_req_valid, fe1_stall;

  // Request-side copy of the fetch in progress.
  logic [PC_W-1:0]   req_pc_q;
  logic              req_specid_q;

  // Presented item; only rewritten when entering HOLD.
  logic [PC_W-1:0]   out_pc_q;
  logic              out_specid_q;
  logic              out_exc_q;
  logic [INSN_W-1:0] out_insn_q;

  assign flush  = bus.de_setpc | bus.csr_kill;
  // Fetch0 output during a flush cycle is wrong-path, so never take it.
  assign accept = bus.fe0_valid & ~fe1_stall & ~flush;

  // State register
  always_ff @(posedge clk_core) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath load strobes
  always_comb begin
    state_d    = state_q;
    load_req   = 1'b0;
    load_fault = 1'b0;
    load_resp  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.fe0_exc) begin state_d = S_HOLD; load_fault = 1'b1; end
          else             begin state_d = S_REQ;  load_req   = 1'b1; end
        end
      end
      S_REQ: begin
        // A request accepted in the flush cycle still owes a response.
        if (flush)                 state_d = bus.ic_req_ready ? S_DRAIN : S_IDLE;
        else if (bus.ic_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush)                  state_d = bus.ic_resp_valid ? S_IDLE : S_DRAIN;
        else if (bus.ic_resp_valid) begin state_d = S_HOLD; load_resp = 1'b1; end
      end
      S_HOLD: begin
        if (flush) state_d = S_IDLE;
        else if (!bus.de_stall) begin
          // Item consumed; a new fetch may be taken in the same cycle.
          if (accept) begin
            if (bus.fe0_exc) begin state_d = S_HOLD; load_fault = 1'b1; end
            else             begin state_d = S_REQ;  load_req   = 1'b1; end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (bus.ic_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    fe1_valid    = (state_q == S_HOLD);
    ic_req_valid = (state_q == S_REQ);
    fe1_stall    = fe1_stalls_fe0(state_q, bus.de_stall);
  end

  // Request and holding registers
  always_ff @(posedge clk_core) begin
    if (reset) begin
      req_pc_q     <= '0;
      req_specid_q <= 1'b0;
      out_pc_q     <= '0;
      out_specid_q <= 1'b0;
      out_exc_q    <= 1'b0;
      out_insn_q   <= '0;
    end else begin
      if (load_req) begin
        req_pc_q     <= bus.fe0_pc;
        req_specid_q <= bus.fe0_specid;
      end
      if (load_fault) begin
        out_pc_q     <= bus.fe0_pc;
        out_specid_q <= bus.fe0_specid;
        out_exc_q    <= 1'b1;
        out_insn_q   <= '0;
      end
      if (load_resp) begin
        out_pc_q     <= req_pc_q;
        out_specid_q <= req_specid_q;
        out_exc_q    <= bus.ic_resp_err;
        out_insn_q   <= bus.ic_resp_err ? '0 : bus.ic_resp_data;
      end
    end
  end

  assign bus.fe1_valid    = fe1_valid;
  assign bus.ic_req_valid = ic_req_valid;
  assign bus.fe1_stall    = fe1_stall;
  assign bus.ic_req_addr  = req_pc_q;
  assign bus.fe1_pc       = out_pc_q;
  assign bus.fe1_specid   = out_specid_q;
  assign bus.fe1_exc      = out_exc_q;
  assign bus.fe1_insn     = out_insn_q;
  assign state            = state_q;

endmodule
